// File: rtl/fft_cfg_seq.sv
// fft_cfg_seq: configuration sequencer for the FFT core's AXI-Stream config
// channel. After reset it waits ARM_CYCLES, then presents one config word
// built from {i_scale_sch, i_fwd_inv} and holds it until the FFT accepts it.
// Run-time resend requests, a sticky handshake timeout flag and a saturating
// completed-transfer counter are provided. All outputs come from flops.
module fft_cfg_seq #(
   parameter int ARM_CYCLES = 16,
   parameter int N_CH       = 1,
   parameter int SCALE_W    = 10,
   parameter int CFG_W      = 16,
   parameter int TIMEOUT    = 1024
) (
   input  logic               i_clk,
   input  logic               i_rstn,
   input  logic [N_CH-1:0]    i_fwd_inv,
   input  logic [SCALE_W-1:0] i_scale_sch,
   input  logic               i_cfg_req,
   input  logic               i_cfg_tready,
   output logic               o_cfg_tvalid,
   output logic [CFG_W-1:0]   o_cfg_tdata,
   output logic               o_cfg_done,
   output logic               o_busy,
   output logic               o_timeout,
   output logic [7:0]         o_cfg_count
);

   // The word must fit the packed direction bits plus the scale schedule.
   generate
      if (CFG_W < N_CH + SCALE_W) begin : g_cfg_w_check
         $error("fft_cfg_seq: CFG_W must be >= N_CH + SCALE_W");
      end
   endgenerate

   localparam logic [1:0] ST_ARM  = 2'd0;
   localparam logic [1:0] ST_SEND = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam int ARM_W = (ARM_CYCLES > 32'sd0) ? $clog2(ARM_CYCLES + 1) : 1;
   localparam int TMO_W = (TIMEOUT > 32'sd0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_CYCLES);
   localparam logic [ARM_W-1:0] ARM_ONE  = ARM_W'(1'b1);
   localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT);
   localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1'b1);
   localparam bit               TMO_EN   = (TIMEOUT > 32'sd0);

   logic [1:0]       state_q, state_d;
   logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;
   logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic             pending_q, pending_d;
   logic             tvalid_q, tvalid_d;
   logic [CFG_W-1:0] tdata_q, tdata_d;
   logic             timeout_q, timeout_d;
   logic [7:0]       count_q, count_d;
   logic             done_q, busy_q;
   logic [CFG_W-1:0] word_s;
   logic             hs_s;

   // Zero-padded config word from the live inputs, direction bits in the LSBs.
   always_comb begin
      word_s = {CFG_W{1'b0}};
      word_s[N_CH+SCALE_W-1:0] = {i_scale_sch, i_fwd_inv};
   end

   // tready only matters while a word is actually on offer.
   assign hs_s = tvalid_q & i_cfg_tready;

   // Next-state logic for the sequencer, timeout and transfer counter.
   always_comb begin
      state_d   = state_q;
      arm_cnt_d = arm_cnt_q;
      tmo_cnt_d = tmo_cnt_q;
      pending_d = pending_q;
      tvalid_d  = tvalid_q;
      tdata_d   = tdata_q;
      timeout_d = timeout_q;
      count_d   = count_q;
      case (state_q)
         ST_ARM: begin
            if (arm_cnt_q == ARM_LAST) begin
               tdata_d  = word_s;
               tvalid_d = 1'b1;
               state_d  = ST_SEND;
            end else begin
               arm_cnt_d = arm_cnt_q + ARM_ONE;
            end
         end
         ST_SEND: begin
            if (hs_s) begin
               if (count_q != 8'hFF) begin
                  count_d = count_q + 8'd1;
               end else begin
                  count_d = count_q;
               end
               tmo_cnt_d = {TMO_W{1'b0}};
               pending_d = 1'b0;
               // A request seen earlier in SEND or on this very edge chains
               // a second transfer with a freshly captured word.
               if (pending_q | i_cfg_req) begin
                  tdata_d  = word_s;
                  tvalid_d = 1'b1;
                  state_d  = ST_SEND;
               end else begin
                  tvalid_d = 1'b0;
                  state_d  = ST_DONE;
               end
            end else begin
               if (i_cfg_req) begin
                  pending_d = 1'b1;
               end else begin
                  pending_d = pending_q;
               end
               if (tmo_cnt_q != TMO_MAX) begin
                  tmo_cnt_d = tmo_cnt_q + TMO_ONE;
               end else begin
                  tmo_cnt_d = tmo_cnt_q;
               end
               // tvalid stays up regardless; the flag only reports the stall.
               if (TMO_EN && (tmo_cnt_d == TMO_MAX)) begin
                  timeout_d = 1'b1;
               end else begin
                  timeout_d = timeout_q;
               end
            end
         end
         ST_DONE: begin
            if (i_cfg_req) begin
               tdata_d  = word_s;
               tvalid_d = 1'b1;
               state_d  = ST_SEND;
            end else begin
               state_d  = ST_DONE;
            end
         end
         default: begin
            state_d  = ST_ARM;
            tvalid_d = 1'b0;
         end
      endcase
   end

   // State and output registers; status flags decoded from the next state.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q   <= ST_ARM;
         arm_cnt_q <= {ARM_W{1'b0}};
         tmo_cnt_q <= {TMO_W{1'b0}};
         pending_q <= 1'b0;
         tvalid_q  <= 1'b0;
         tdata_q   <= {CFG_W{1'b0}};
         timeout_q <= 1'b0;
         count_q   <= 8'd0;
         done_q    <= 1'b0;
         busy_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         arm_cnt_q <= arm_cnt_d;
         tmo_cnt_q <= tmo_cnt_d;
         pending_q <= pending_d;
         tvalid_q  <= tvalid_d;
         tdata_q   <= tdata_d;
         timeout_q <= timeout_d;
         count_q   <= count_d;
         done_q    <= (state_d == ST_DONE);
         busy_q    <= (state_d != ST_DONE);
      end
   end

   assign o_cfg_tvalid = tvalid_q;
   assign o_cfg_tdata  = tdata_q;
   assign o_cfg_done   = done_q;
   assign o_busy       = busy_q;
   assign o_timeout    = timeout_q;
   assign o_cfg_count  = count_q;

endmodule

// File: tb/tb_fft_cfg_seq.sv
// Self-checking bench for fft_cfg_seq. Expected config words are queued as
// stimulus is applied and popped by a monitor at each observed handshake.
module tb_fft_cfg_seq;

   localparam int ARM = 16;

   logic        clk;
   logic        rstn;
   logic [0:0]  fwd_inv;
   logic [9:0]  scale_sch;
   logic        cfg_req;
   logic        tready;
   logic        tvalid;
   logic [15:0] tdata;
   logic        done;
   logic        busy;
   logic        timeout;
   logic [7:0]  count;

   int          errors = 0;
   int          checks = 0;
   logic [15:0] sb[$];
   logic [15:0] exp_w;

   fft_cfg_seq #(
      .ARM_CYCLES(ARM), .N_CH(1), .SCALE_W(10), .CFG_W(16), .TIMEOUT(8)
   ) dut (
      .i_clk(clk), .i_rstn(rstn), .i_fwd_inv(fwd_inv), .i_scale_sch(scale_sch),
      .i_cfg_req(cfg_req), .i_cfg_tready(tready), .o_cfg_tvalid(tvalid),
      .o_cfg_tdata(tdata), .o_cfg_done(done), .o_busy(busy),
      .o_timeout(timeout), .o_cfg_count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Handshake monitor: the word on offer must match the scoreboard head.
   always @(negedge clk) begin
      if (rstn && tvalid && tready) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_empty: handshake with tdata=%h but no word expected", tdata);
         end else begin
            exp_w = sb.pop_front();
            if (tdata !== exp_w) begin
               errors++;
               $display("FAIL sb_word: tdata=%h expected %h", tdata, exp_w);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   task automatic check_reset_values(input string tag);
      checks++;
      if ({tvalid, tdata, done, busy, timeout, count} !== {1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'd0}) begin
         errors++;
         $display("FAIL %s: tvalid=%b tdata=%h done=%b busy=%b timeout=%b count=%0d expected 0/0000/0/1/0/0",
                  tag, tvalid, tdata, done, busy, timeout, count);
      end
   endtask

   // Hold reset for a few cycles, check reset outputs, release just after an edge.
   task automatic test_reset();
      rstn = 1'b0;
      cfg_req = 1'b0;
      repeat (3) step();
      check_reset_values("reset_values");
      sb.delete();
      rstn = 1'b1;
   endtask

   // tvalid must stay low through ARM and rise after edge ARM+1.
   task automatic wait_first_valid(input string tag);
      for (int k = 1; k <= ARM + 1; k++) begin
         step();
         checks++;
         if (tvalid !== (k == ARM + 1)) begin
            errors++;
            $display("FAIL %s_arm_edge%0d: tvalid=%b expected %b", tag, k, tvalid, (k == ARM + 1));
         end
      end
   endtask

   task automatic test_first_word();
      fwd_inv = 1'b1; scale_sch = 10'h2AB; tready = 1'b1;
      test_reset();
      sb.push_back(16'h0557);
      wait_first_valid("first");
      chk("first_tdata", tdata, 16'h0557);
      chk("first_busy", {15'd0, busy}, 16'd1);
      step();
      chk("first_tvalid_drop", {15'd0, tvalid}, 16'd0);
      chk("first_count", {8'd0, count}, 16'd1);
      chk("first_done", {15'd0, done}, 16'd1);
      chk("first_busy_idle", {15'd0, busy}, 16'd0);
   endtask

   task automatic test_req_in_done();
      tready = 1'b0; fwd_inv = 1'b0; scale_sch = 10'h155; cfg_req = 1'b1;
      sb.push_back(16'h02AA);
      step();
      cfg_req = 1'b0;
      chk("req_tvalid", {15'd0, tvalid}, 16'd1);
      chk("req_tdata", tdata, 16'h02AA);
      chk("req_done_low", {15'd0, done}, 16'd0);
      tready = 1'b1;
      step();
      chk("req_count", {8'd0, count}, 16'd2);
      chk("req_done", {15'd0, done}, 16'd1);
   endtask

   task automatic test_backpressure();
      tready = 1'b0; fwd_inv = 1'b1; scale_sch = 10'h3C3; cfg_req = 1'b1;
      sb.push_back(16'h0787);
      step();
      cfg_req = 1'b0;
      for (int i = 0; i < 20; i++) begin
         fwd_inv = ~fwd_inv;
         scale_sch = 10'($urandom);
         step();
         chk("bp_tvalid_hold", {15'd0, tvalid}, 16'd1);
         chk("bp_tdata_hold", tdata, 16'h0787);
      end
      tready = 1'b1;
      step();
      chk("bp_tvalid_after", {15'd0, tvalid}, 16'd0);
      chk("bp_count", {8'd0, count}, 16'd3);
   endtask

   task automatic test_timeout();
      fwd_inv = 1'b1; scale_sch = 10'h0AA; tready = 1'b0;
      test_reset();
      sb.push_back(16'h0155);
      wait_first_valid("tmo");
      for (int i = 1; i <= 8; i++) begin
         step();
         checks++;
         if (timeout !== (i == 8)) begin
            errors++;
            $display("FAIL tmo_flag_cycle%0d: timeout=%b expected %b", i, timeout, (i == 8));
         end
         chk("tmo_tvalid_held", {15'd0, tvalid}, 16'd1);
      end
      tready = 1'b1;
      step();
      chk("tmo_sticky", {15'd0, timeout}, 16'd1);
      chk("tmo_count", {8'd0, count}, 16'd1);
      chk("tmo_done", {15'd0, done}, 16'd1);
   endtask

   task automatic test_back_to_back();
      tready = 1'b0; fwd_inv = 1'b0; scale_sch = 10'h111; cfg_req = 1'b1;
      sb.push_back(16'h0222);
      step();
      cfg_req = 1'b0;
      chk("b2b_first_tdata", tdata, 16'h0222);
      tready = 1'b1; fwd_inv = 1'b1; scale_sch = 10'h2CC; cfg_req = 1'b1;
      sb.push_back(16'h0599);
      step();
      cfg_req = 1'b0;
      chk("b2b_tvalid_kept", {15'd0, tvalid}, 16'd1);
      chk("b2b_relatched", tdata, 16'h0599);
      chk("b2b_count_mid", {8'd0, count}, 16'd2);
      step();
      chk("b2b_tvalid_drop", {15'd0, tvalid}, 16'd0);
      chk("b2b_count_end", {8'd0, count}, 16'd3);
      chk("b2b_done", {15'd0, done}, 16'd1);
   endtask

   task automatic test_reset_mid_send();
      tready = 1'b0; fwd_inv = 1'b1; scale_sch = 10'h3FF; cfg_req = 1'b1;
      sb.push_back(16'h07FF);
      step();
      cfg_req = 1'b0;
      chk("mid_tvalid_before", {15'd0, tvalid}, 16'd1);
      #2;
      rstn = 1'b0;
      #1;
      check_reset_values("mid_async_reset");
      sb.delete();
      step();
      fwd_inv = 1'b0; scale_sch = 10'h001; tready = 1'b1;
      rstn = 1'b1;
      sb.push_back(16'h0002);
      wait_first_valid("mid_rearm");
      chk("mid_rearm_tdata", tdata, 16'h0002);
      step();
      chk("mid_rearm_count", {8'd0, count}, 16'd1);
   endtask

   initial begin
      rstn = 1'b0; fwd_inv = 1'b0; scale_sch = 10'h000; cfg_req = 1'b0; tready = 1'b0;
      test_first_word();
      test_req_in_done();
      test_backpressure();
      test_timeout();
      test_back_to_back();
      test_reset_mid_send();
      repeat (2) step();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover: %0d words never handshaken, expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fft_cfg_seq.md
Name: fft_cfg_seq

Overview:
- Parametrised configuration sequencer for the FFT core's AXI-Stream config channel.
- After reset, waits ARM_CYCLES, then presents one config word built from the per-channel direction bits and the scale schedule.
- Holds the word until the FFT accepts it via tready.
- Supports run-time re-configuration requests, a handshake timeout flag and a completed-transfer counter, for use alongside multi-channel FFT instances.

Parameters:
- ARM_CYCLES, 16, idle cycles after reset release before the first config word is presented.
- N_CH, 1, number of FFT channels; one fwd/inv bit each.
- SCALE_W, 10, width of the scale schedule field.
- CFG_W, 16, config tdata width; must be >= N_CH+SCALE_W (elaboration error otherwise).
- TIMEOUT, 1024, cycles waiting in SEND before o_timeout asserts; 0 disables the timeout.

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  asynchronous active-low reset
- i_fwd_inv  in  N_CH  per-channel direction, 1=forward, 0=inverse
- i_scale_sch  in  SCALE_W  scale schedule
- i_cfg_req  in  1  single-cycle request to resend config with current inputs
- i_cfg_tready  in  1  FFT config ready
- o_cfg_tvalid  out  1  config word valid
- o_cfg_tdata  out  CFG_W  zero-padded {i_scale_sch, i_fwd_inv}; fwd_inv in the LSBs
- o_cfg_done  out  1  high while idle with the last config accepted
- o_busy  out  1  high in ARM or SEND
- o_timeout  out  1  sticky timeout flag
- o_cfg_count  out  8  completed handshakes, saturates at 255

Behaviour:
- Reset (asynchronous, i_rstn low):
  - state=ARM, arm_count=0, pending=0, timeout counter=0.
  - o_cfg_tvalid=0, o_cfg_tdata=0, o_cfg_done=0, o_busy=1, o_timeout=0, o_cfg_count=0.
- State ARM:
  - arm_count increments each cycle.
  - In the cycle arm_count==ARM_CYCLES: latch {i_scale_sch, i_fwd_inv} into o_cfg_tdata, set o_cfg_tvalid, go to SEND.
  - o_cfg_tvalid is therefore first high after the (ARM_CYCLES+1)th rising edge following reset release. ARM_CYCLES=0 gives the first edge.
  - i_cfg_req during ARM is ignored, because the latch at ARM exit already captures the current inputs.
- State SEND:
  - o_cfg_tvalid=1; o_cfg_tdata stays stable until the handshake. Inputs changing during SEND do not affect the word in flight.
  - Handshake occurs on an edge with o_cfg_tvalid && i_cfg_tready. On that edge:
    - o_cfg_count increments (saturating).
    - The timeout counter clears.
  - After the handshake, if pending=1: clear pending, re-latch tdata from the current inputs on the same edge, keep tvalid high, stay in SEND (back-to-back transfer).
  - After the handshake, if pending=0: tvalid<=0, go to DONE.
  - i_cfg_req in SEND, including the handshake cycle itself, sets pending.
- State DONE:
  - o_cfg_done=1, o_busy=0, tvalid=0; o_cfg_tdata holds the last word.
  - i_cfg_req: latch the inputs, tvalid<=1, o_cfg_done<=0, go to SEND on the next edge. No re-arm delay.
- Timeout:
  - In SEND, the counter increments each cycle without a handshake.
  - When the counter reaches TIMEOUT (TIMEOUT>0), o_timeout<=1, sticky until reset.
  - tvalid is never dropped on timeout (AXI rule); the sequencer keeps waiting.
  - The counter saturates at TIMEOUT.
- i_cfg_tready is ignored when tvalid=0; no combinational path from tready to any output.
- Reset asserted mid-SEND drops tvalid immediately (async) and restarts ARM; the partial transfer is discarded.
- All outputs are registered; o_busy and o_cfg_done are decoded from registered state.

Test Plan:
- Reset release, tready=1 held, ARM_CYCLES=16:
  - o_cfg_tvalid first high after edge 17, high for exactly 1 cycle.
  - With i_fwd_inv=1, i_scale_sch=10'h2AB: tdata=16'h0557.
  - o_cfg_count=1, o_cfg_done=1 the following cycle.
- tready=0 for 20 cycles after tvalid rises, inputs toggled meanwhile:
  - tvalid stays high and tdata unchanged throughout.
  - Handshake completes on the first tready=1 edge.
- TIMEOUT=8, tready held 0:
  - o_timeout rises after 8 SEND cycles, tvalid still 1.
  - Then tready=1: transfer completes, o_timeout stays 1.
- In DONE, pulse i_cfg_req with i_fwd_inv=0, i_scale_sch=10'h155:
  - tvalid high the next cycle with tdata=16'h02AA.
  - o_cfg_count increments to 2 on accept.
- i_cfg_req pulsed on the same cycle as a handshake:
  - tvalid remains high with the re-latched word.
  - A second handshake follows, count +2 total, then DONE.
- Reset asserted while tvalid=1, tready=0:
  - All outputs return to reset values immediately.
  - After release, the full ARM_CYCLES delay repeats before tvalid.
